// File: rtl/game_status_ctrl.sv
// Game-flow scene sequencer: drives the status bus that every sprite module and the color mapper decode.
// prev_key follows keycode even while Reset is held, so a key held across reset does not count as a fresh press.
//
// state    | meaning
// TITLE    | title screen, Enter starts the intro
// INTRO    | intro text, Enter or timeout moves to map 1
// MAP1     | first map, exit tile starts the battle, Esc aborts
// BATTLE   | battle scene, hp_zero loses, battle_won opens map 2
// MAP2     | second map, exit tile wins, Esc aborts
// GAMEOVER | loss screen, Enter accepted only after a minimum display time
// WIN      | victory screen, Enter returns to title
module game_status_ctrl #(
  parameter logic [7:0] INTRO_FRAMES        = 8'd120,
  parameter logic [7:0] GAMEOVER_MIN_FRAMES = 8'd60,
  parameter logic [7:0] KEY_ENTER           = 8'h28,
  parameter logic [7:0] KEY_ESC             = 8'h29
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       exit_reached,
  input  logic       battle_won,
  input  logic       hp_zero,
  output logic [3:0] status,
  output logic       status_entry,
  output logic [7:0] frame_cnt
);

  typedef enum logic [3:0] {
    TITLE    = 4'd0,
    INTRO    = 4'd1,
    MAP1     = 4'd2,
    BATTLE   = 4'd3,
    MAP2     = 4'd4,
    GAMEOVER = 4'd5,
    WIN      = 4'd6
  } scene_e;

  logic [3:0] state;
  logic [7:0] prev_key;
  logic       fsync1, fsync2, fsync3;
  logic       frame_tick, enter_edge, esc_edge;

  assign frame_tick = fsync2 & ~fsync3;
  assign enter_edge = (keycode == KEY_ENTER) && (prev_key != KEY_ENTER);
  assign esc_edge   = (keycode == KEY_ESC) && (prev_key != KEY_ESC);
  assign status     = state;

  always_ff @(posedge Clk) begin
    prev_key <= keycode;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsync1 <= 1'b0;
      fsync2 <= 1'b0;
      fsync3 <= 1'b0;
    end else begin
      fsync1 <= frame_clk;
      fsync2 <= fsync1;
      fsync3 <= fsync2;
    end
  end

  // Later assignments in the case override the frame counter update, so a tick on a transition is dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= TITLE;
      status_entry <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      status_entry <= 1'b0;
      if (frame_tick && (frame_cnt != 8'hFF)) frame_cnt <= frame_cnt + 8'd1;
      case (state)
        TITLE: begin
          if (enter_edge) begin
            state <= INTRO; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end
        end
        INTRO: begin
          if (enter_edge || (frame_cnt == INTRO_FRAMES)) begin
            state <= MAP1; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end
        end
        MAP1: begin
          if (exit_reached) begin
            state <= BATTLE; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end else if (esc_edge) begin
            state <= TITLE; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end
        end
        BATTLE: begin
          if (hp_zero) begin
            state <= GAMEOVER; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end else if (battle_won) begin
            state <= MAP2; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end
        end
        MAP2: begin
          if (exit_reached) begin
            state <= WIN; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end else if (esc_edge) begin
            state <= TITLE; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end
        end
        GAMEOVER: begin
          if (enter_edge && (frame_cnt >= GAMEOVER_MIN_FRAMES)) begin
            state <= TITLE; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end
        end
        WIN: begin
          if (enter_edge) begin
            state <= TITLE; status_entry <= 1'b1; frame_cnt <= 8'd0;
          end
        end
        default: begin
          state <= TITLE; status_entry <= 1'b1; frame_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
